prga: RTL

ARC4 pseudo-random generation stage: the responder side of the `en`/`rdy` start handshake that top-level controllers initiate. On a start request it reads a length-prefixed ciphertext from `ct_mem`, advances the ARC4 keystream over an already-initialised S array in `s_mem`, and writes the length-prefixed plaintext to `pt_mem`. It sits behind the key-schedule stages and shares S memory with them, which it accesses only while busy.

---
 rtl/arc4_pkg.sv | 26 ++
 rtl/prga.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/arc4_pkg.sv
// ARC4 shared definitions: byte width, S-array depth, message layout and the
// PRGA state encoding.
package arc4_pkg;

  localparam int unsigned ARC4_W     = 8;
  localparam int unsigned ARC4_DEPTH = 256;

  // Byte offset of the length field inside ct/pt messages.
  localparam int unsigned LEN_OFFSET = 0;

  typedef logic [ARC4_W-1:0] arc4_byte_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_LEN,
    ST_LEN,
    ST_RD_SI,
    ST_SI,
    ST_SJ,
    ST_WR_SJ,
    ST_RD_PAD,
    ST_PAD,
    ST_DONE
  } prga_state_t;

endpackage

// File: rtl/prga.sv
// ARC4 pseudo-random generation stage. On an en/rdy start it reads a
// length-prefixed ciphertext from ct memory, runs the ARC4 keystream over the
// S array in s memory (swapping in place) and writes the length-prefixed
// plaintext to pt memory. All memories are synchronous, 1-cycle read latency.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   en / rdy              start request / idle-and-ready
//   s_addr/s_rddata/s_wrdata/s_wren     S array port
//   ct_addr/ct_rddata                   ciphertext (read only)
//   pt_addr/pt_rddata/pt_wrdata/pt_wren plaintext (pt_rddata unused)
//
// Memory interface signals are decoded from the state register: addresses
// issued in a state are sampled by the memory on the edge leaving it, and the
// write data is taken from read data arriving in that same state, so these
// cannot be pre-registered without adding cycles per byte.
module prga
  import arc4_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  output logic [ARC4_W-1:0] s_addr,
  input  logic [ARC4_W-1:0] s_rddata,
  output logic [ARC4_W-1:0] s_wrdata,
  output logic              s_wren,
  output logic [ARC4_W-1:0] ct_addr,
  input  logic [ARC4_W-1:0] ct_rddata,
  output logic [ARC4_W-1:0] pt_addr,
  input  logic [ARC4_W-1:0] pt_rddata,
  output logic [ARC4_W-1:0] pt_wrdata,
  output logic              pt_wren
);

  prga_state_t state;
  arc4_byte_t  i;
  arc4_byte_t  j;
  arc4_byte_t  k;
  arc4_byte_t  len;
  arc4_byte_t  si;
  arc4_byte_t  sj;
  arc4_byte_t  ct_byte;

  // pt memory is write-only from this block.
  logic unused_pt_rddata;
  assign unused_pt_rddata = ^pt_rddata;

  // State sequencing and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      i       <= '0;
      j       <= '0;
      k       <= '0;
      len     <= '0;
      si      <= '0;
      sj      <= '0;
      ct_byte <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en) state <= ST_RD_LEN;
        end
        ST_RD_LEN: begin
          state <= ST_LEN;
        end
        ST_LEN: begin
          len <= ct_rddata;
          i   <= '0;
          j   <= '0;
          k   <= ARC4_W'(1);
          state <= (ct_rddata == '0) ? ST_DONE : ST_RD_SI;
        end
        ST_RD_SI: begin
          i     <= i + ARC4_W'(1);
          state <= ST_SI;
        end
        ST_SI: begin
          si    <= s_rddata;
          j     <= j + s_rddata;
          state <= ST_SJ;
        end
        ST_SJ: begin
          sj    <= s_rddata;
          state <= ST_WR_SJ;
        end
        ST_WR_SJ: begin
          state <= ST_RD_PAD;
        end
        ST_RD_PAD: begin
          ct_byte <= ct_rddata;
          state   <= ST_PAD;
        end
        ST_PAD: begin
          if (k == len) begin
            state <= ST_DONE;
          end else begin
            k     <= k + ARC4_W'(1);
            state <= ST_RD_SI;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory port decode; everything is zero outside the states that use it.
  always_comb begin
    rdy       = 1'b0;
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    ct_addr   = '0;
    pt_addr   = '0;
    pt_wrdata = '0;
    pt_wren   = 1'b0;
    case (state)
      ST_IDLE:   rdy = 1'b1;
      ST_RD_LEN: ct_addr = ARC4_W'(LEN_OFFSET);
      ST_LEN: begin
        pt_addr   = ARC4_W'(LEN_OFFSET);
        pt_wrdata = ct_rddata;
        pt_wren   = 1'b1;
      end
      ST_RD_SI:  s_addr = i + ARC4_W'(1);
      ST_SI:     s_addr = j + s_rddata;
      // S[j] arrives now; store it at S[i]. When i==j both writes hit the
      // same word with its own value, leaving S unchanged as ARC4 requires.
      ST_SJ: begin
        s_addr   = i;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
      end
      ST_WR_SJ: begin
        s_addr   = j;
        s_wrdata = si;
        s_wren   = 1'b1;
        ct_addr  = k;
      end
      ST_RD_PAD: s_addr = si + sj;
      ST_PAD: begin
        pt_addr   = k;
        pt_wrdata = s_rddata ^ ct_byte;
        pt_wren   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
